mini_src_datapath: RTL and testbench
====================================

// Module: mini_src_datapath
// PURPOSE
// - 32-bit single-bus datapath of the Mini SRC CPU: register file slice (R1-R5), PC, IR, MAR, MDR,
//   Y, 64-bit Z, HI, LO and the ALU, all exchanging data over one shared 32-bit bus.
// - Driven cycle-by-cycle by an external control unit through per-register enable (e_*) and
//   bus-select (s_*) strobes; memory data enters via w_Mdatain into MDR.
// PARAMETERS
// - WIDTH  32  datapath/bus width; all registers except Z are WIDTH bits, Z is 2*WIDTH.
// PORTS
// - w_clock    in   1   sole clock; all state updates on rising edge
// - w_clear    in   1   reset, asynchronous, active-high; clears every register to 0
// - w_IncPC    in   1   ALU computes bus+1 (PC increment); overrides e_alu
// - e_R1..e_R5 in   1   each: load register Rn from bus
// - e_MAR, e_PC, e_IR, e_Y, e_HI, e_LO  in  1  each: load that register from bus
// - e_MDR      in   1   load MDR from MDR input mux
// - e_Z        in   1   load 64-bit Z from ALU result
// - s_PC, s_Zlow, s_Zhigh, s_MDR, s_R2..s_R5  in  1  bus-source selects (one-hot expected)
// - w_read     in   1   MDR mux select: 1 = w_Mdatain, 0 = bus
// - e_alu      in   1   ALU computes operation given by opcode
// - opcode     in   6   ALU op (bits [4:0] decoded; bit 5 ignored)
// - w_Mdatain  in   32  memory read data
// - o_bus      out  32  current bus value
// - o_PC, o_IR, o_MAR, o_HI, o_LO  out 32  register contents
// - o_Z        out  64  {Zhigh, Zlow}
// BEHAVIOUR
// - Reset: all registers and outputs 0 immediately on w_clear high; held while high.
// - Bus (combinational): priority PC > Zhigh > Zlow > MDR > R2 > R3 > R4 > R5; no select -> 0.
// - R1 is write-only from bus (no bus select exists for it).
// - Registers load bus on rising edge when their enable is high; otherwise hold. Same-edge
//   read-then-write is legal (old value on bus, new value after edge).
// - ALU (combinational): A = Y, B = bus, result 64-bit R.
//   w_IncPC: R = {32'h0, B+1}. Else e_alu per opcode[4:0]; else R = 0.
//   0 add A+B; 1 sub A-B; 2 and; 3 or; 4 not ~B; 12 neg -B; all wrap mod 2^32, Rhi=0.
//   7 rol / 8 ror / 9 shr logical / 10 shra arithmetic / 11 shl: A shifted by B[4:0], Rhi=0.
//   5 mul: signed A*B, full 64-bit product in R.
//   6 div: signed truncating A/B: Rlo=quotient, Rhi=remainder (sign of A).
//   div by 0: Rlo=32'hFFFFFFFF, Rhi=A. Overflow (-2^31 / -1): Rlo=32'h80000000, Rhi=0.
//   Opcodes 13-31: R = 0.
// - Z loads R on rising edge when e_Z; HI/LO are loaded only via bus (Zhigh/Zlow selects).
// - Single-cycle latency for every transfer; no handshakes, no internal FSM.
// CONFIGURATION
// - MINI_SRC_MULDIV_EN defined: mul (5) and div (6) implemented as above.
// - Undefined: opcodes 5 and 6 yield R = 0 (no multiplier/divider hardware synthesized).
// TESTING (MINI_SRC_MULDIV_EN defined)
// - Load: w_Mdatain=21, w_read+e_MDR 1 edge, then s_MDR+e_R4 -> R4=21; likewise R5=7, R1=0x18.
// - PC fetch: s_PC+e_MAR+w_IncPC+e_Z from reset -> MAR=0, Z=1; s_Zlow+e_PC -> PC=1.
// - Div: s_R4+e_Y; s_R5+e_alu(op 6)+e_Z -> Z={0,3}; s_Zlow+e_LO -> LO=3; s_Zhigh+e_HI -> HI=0.
// - Mul: Y=0xFFFFFFFF(-1), bus=2, op 5 -> Z=64'hFFFFFFFF_FFFFFFFE; div by 0: Y=9,B=0 -> Z={9,FFFFFFFF}.
// - Shifts: Y=0x80000001,B=1: rol->3, ror->0xC0000000, shr->0x40000000, shra->0xC0000000.
// - Async clear mid-sequence (no clock edge): all regs and o_* read 0 immediately.

Source files
------------

// File: rtl/mini_src_datapath_if.sv
// Signal bundle between the Mini SRC control unit (master) and the single-bus datapath (slave).
interface mini_src_datapath_if #(
  parameter int unsigned WIDTH = 32
);
  logic             w_IncPC;
  logic             e_R1, e_R2, e_R3, e_R4, e_R5;
  logic             e_MAR, e_PC, e_IR, e_Y, e_HI, e_LO, e_MDR, e_Z;
  logic             s_PC, s_Zlow, s_Zhigh, s_MDR, s_R2, s_R3, s_R4, s_R5;
  logic             w_read;
  logic             e_alu;
  logic [5:0]       opcode;
  logic [WIDTH-1:0] w_Mdatain;

  logic [WIDTH-1:0]   o_bus;
  logic [WIDTH-1:0]   o_PC, o_IR, o_MAR, o_HI, o_LO;
  logic [2*WIDTH-1:0] o_Z;

  modport master (
    output w_IncPC,
    output e_R1, e_R2, e_R3, e_R4, e_R5,
    output e_MAR, e_PC, e_IR, e_Y, e_HI, e_LO, e_MDR, e_Z,
    output s_PC, s_Zlow, s_Zhigh, s_MDR, s_R2, s_R3, s_R4, s_R5,
    output w_read, e_alu, opcode, w_Mdatain,
    input  o_bus, o_PC, o_IR, o_MAR, o_HI, o_LO, o_Z
  );

  modport slave (
    input  w_IncPC,
    input  e_R1, e_R2, e_R3, e_R4, e_R5,
    input  e_MAR, e_PC, e_IR, e_Y, e_HI, e_LO, e_MDR, e_Z,
    input  s_PC, s_Zlow, s_Zhigh, s_MDR, s_R2, s_R3, s_R4, s_R5,
    input  w_read, e_alu, opcode, w_Mdatain,
    output o_bus, o_PC, o_IR, o_MAR, o_HI, o_LO, o_Z
  );
endinterface

// File: rtl/mini_src_datapath.sv
// Mini SRC single-bus datapath: registers, 64-bit Z and ALU sharing one bus.
// Define MINI_SRC_MULDIV_EN to build the signed multiplier/divider (opcodes 5 and 6).
module mini_src_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input logic                w_clock,
  input logic                w_clear,
  mini_src_datapath_if.slave dp
);
  localparam int unsigned      SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_NOT  = 5'd4,
    OP_MUL  = 5'd5,
    OP_DIV  = 5'd6,
    OP_ROL  = 5'd7,
    OP_ROR  = 5'd8,
    OP_SHR  = 5'd9,
    OP_SHRA = 5'd10,
    OP_SHL  = 5'd11,
    OP_NEG  = 5'd12
  } alu_op_e;

  logic [WIDTH-1:0]   r1, r2, r3, r4, r5;
  logic [WIDTH-1:0]   pc, ir, mar, mdr, y, hi, lo;
  logic [2*WIDTH-1:0] z;
  logic [WIDTH-1:0]   bus, mdr_in;
  logic [WIDTH-1:0]   alu_lo, alu_hi;
  logic [2*WIDTH-1:0] dbl, rot_l, rot_r;
  logic [SHW-1:0]     sh;
  alu_op_e            op;
  logic               unused;

  // R1 has no bus driver and opcode[5] is not decoded.
  assign unused = ^{dp.opcode[5], r1};

  always_comb begin
    bus = '0;
    if      (dp.s_PC)    bus = pc;
    else if (dp.s_Zhigh) bus = z[2*WIDTH-1:WIDTH];
    else if (dp.s_Zlow)  bus = z[WIDTH-1:0];
    else if (dp.s_MDR)   bus = mdr;
    else if (dp.s_R2)    bus = r2;
    else if (dp.s_R3)    bus = r3;
    else if (dp.s_R4)    bus = r4;
    else if (dp.s_R5)    bus = r5;
  end

  assign mdr_in = dp.w_read ? dp.w_Mdatain : bus;

  // Rotates take the relevant half of Y concatenated with itself.
  assign sh    = bus[SHW-1:0];
  assign dbl   = {y, y};
  assign rot_l = dbl << sh;
  assign rot_r = dbl >> sh;
  assign op    = alu_op_e'(dp.opcode[4:0]);

`ifdef MINI_SRC_MULDIV_EN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign prod = {{WIDTH{y[WIDTH-1]}}, y} * {{WIDTH{bus[WIDTH-1]}}, bus};

  always_comb begin
    if (bus == '0) begin
      quo = '1;
      rem = y;
    end else if (y == MIN && bus == '1) begin
      quo = MIN;
      rem = '0;
    end else begin
      quo = $signed(y) / $signed(bus);
      rem = $signed(y) % $signed(bus);
    end
  end
`endif

  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    if (dp.w_IncPC) begin
      alu_lo = bus + ONE;
    end else if (dp.e_alu) begin
      case (op)
        OP_ADD:  alu_lo = y + bus;
        OP_SUB:  alu_lo = y - bus;
        OP_AND:  alu_lo = y & bus;
        OP_OR:   alu_lo = y | bus;
        OP_NOT:  alu_lo = ~bus;
        OP_NEG:  alu_lo = '0 - bus;
        OP_ROL:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
        OP_ROR:  alu_lo = rot_r[WIDTH-1:0];
        OP_SHR:  alu_lo = y >> sh;
        OP_SHRA: alu_lo = $signed(y) >>> sh;
        OP_SHL:  alu_lo = y << sh;
`ifdef MINI_SRC_MULDIV_EN
        OP_MUL:  {alu_hi, alu_lo} = prod;
        OP_DIV: begin
          alu_lo = quo;
          alu_hi = rem;
        end
`endif
        default: alu_lo = '0;
      endcase
    end
  end

  always_ff @(posedge w_clock or posedge w_clear) begin
    if (w_clear) begin
      r1  <= '0;
      r2  <= '0;
      r3  <= '0;
      r4  <= '0;
      r5  <= '0;
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      hi  <= '0;
      lo  <= '0;
      z   <= '0;
    end else begin
      if (dp.e_R1)  r1  <= bus;
      if (dp.e_R2)  r2  <= bus;
      if (dp.e_R3)  r3  <= bus;
      if (dp.e_R4)  r4  <= bus;
      if (dp.e_R5)  r5  <= bus;
      if (dp.e_PC)  pc  <= bus;
      if (dp.e_IR)  ir  <= bus;
      if (dp.e_MAR) mar <= bus;
      if (dp.e_MDR) mdr <= mdr_in;
      if (dp.e_Y)   y   <= bus;
      if (dp.e_HI)  hi  <= bus;
      if (dp.e_LO)  lo  <= bus;
      if (dp.e_Z)   z   <= {alu_hi, alu_lo};
    end
  end

  assign dp.o_bus = bus;
  assign dp.o_PC  = pc;
  assign dp.o_IR  = ir;
  assign dp.o_MAR = mar;
  assign dp.o_HI  = hi;
  assign dp.o_LO  = lo;
  assign dp.o_Z   = z;
endmodule

// File: tb/tb_mini_src_datapath.sv
// Scoreboard bench for mini_src_datapath; mul/div expectations follow MINI_SRC_MULDIV_EN.
module tb_mini_src_datapath;
  localparam int unsigned W = 32;
`ifdef MINI_SRC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef enum int {S_PC, S_IR, S_MAR, S_HI, S_LO, S_Z} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic w_clock = 1'b0;
  logic w_clear;

  logic [31:0] m_pc, m_mdr, m_y, m_hi, m_lo, m_r2, m_r3, m_r4, m_r5;
  logic [63:0] m_z;

  mini_src_datapath_if #(.WIDTH(W)) dp();

  mini_src_datapath #(.WIDTH(W)) dut (
    .w_clock (w_clock),
    .w_clear (w_clear),
    .dp      (dp.slave)
  );

  always #5 w_clock = ~w_clock;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_val(input sel_e s);
    case (s)
      S_PC:    return {32'h0, dp.o_PC};
      S_IR:    return {32'h0, dp.o_IR};
      S_MAR:   return {32'h0, dp.o_MAR};
      S_HI:    return {32'h0, dp.o_HI};
      S_LO:    return {32'h0, dp.o_LO};
      default: return dp.o_Z;
    endcase
  endfunction

  // Independent reference: bit-serial shifts, 64-bit integer mul/div.
  function automatic logic [63:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] x;
    int          ia, ib;
    longint      la, lb, q, r;
    x  = a;
    ia = a;
    ib = b;
    la = ia;
    lb = ib;
    case (op[4:0])
      5'd0:  return {32'h0, a + b};
      5'd1:  return {32'h0, a - b};
      5'd2:  return {32'h0, a & b};
      5'd3:  return {32'h0, a | b};
      5'd4:  return {32'h0, ~b};
      5'd12: return {32'h0, 32'h0 - b};
      5'd7:  begin repeat (int'(b[4:0])) x = {x[30:0], x[31]};  return {32'h0, x}; end
      5'd8:  begin repeat (int'(b[4:0])) x = {x[0], x[31:1]};   return {32'h0, x}; end
      5'd9:  begin repeat (int'(b[4:0])) x = {1'b0, x[31:1]};   return {32'h0, x}; end
      5'd10: begin repeat (int'(b[4:0])) x = {x[31], x[31:1]};  return {32'h0, x}; end
      5'd11: begin repeat (int'(b[4:0])) x = {x[30:0], 1'b0};   return {32'h0, x}; end
      5'd5:  return MD ? 64'(la * lb) : 64'h0;
      5'd6: begin
        if (!MD) return 64'h0;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 64'h0000_0000_8000_0000;
        q = la / lb;
        r = la - q * lb;
        return {r[31:0], q[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic idle();
    dp.w_IncPC = 0; dp.e_R1 = 0; dp.e_R2 = 0; dp.e_R3 = 0; dp.e_R4 = 0; dp.e_R5 = 0;
    dp.e_MAR = 0; dp.e_PC = 0; dp.e_IR = 0; dp.e_Y = 0; dp.e_HI = 0; dp.e_LO = 0;
    dp.e_MDR = 0; dp.e_Z = 0; dp.s_PC = 0; dp.s_Zlow = 0; dp.s_Zhigh = 0; dp.s_MDR = 0;
    dp.s_R2 = 0; dp.s_R3 = 0; dp.s_R4 = 0; dp.s_R5 = 0; dp.w_read = 0; dp.e_alu = 0;
    dp.opcode = '0; dp.w_Mdatain = '0;
  endtask

  task automatic expect_reg(input string tag, input sel_e sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge w_clock);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, dut_val(e.sel), e.exp);
    end
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    dp.w_Mdatain = v; dp.w_read = 1; dp.e_MDR = 1;
    tick();
    m_mdr = v;
  endtask

  task automatic set_y(input logic [31:0] v);
    load_mdr(v);
    dp.s_MDR = 1; dp.e_Y = 1;
    tick();
    m_y = v;
  endtask

  task automatic alu_op(input string tag, input logic [5:0] op, input logic [31:0] b,
                        input logic [63:0] exp);
    load_mdr(b);
    dp.s_MDR = 1; dp.e_alu = 1; dp.opcode = op; dp.e_Z = 1;
    expect_reg(tag, S_Z, exp);
    tick();
    m_z = exp;
  endtask

  task automatic z_to_hilo(input string tag);
    dp.s_Zlow = 1; dp.e_LO = 1;
    expect_reg({tag, "_lo"}, S_LO, {32'h0, m_z[31:0]});
    tick();
    m_lo = m_z[31:0];
    dp.s_Zhigh = 1; dp.e_HI = 1;
    expect_reg({tag, "_hi"}, S_HI, {32'h0, m_z[63:32]});
    tick();
    m_hi = m_z[63:32];
  endtask

  task automatic load_rn(input int n, input logic [31:0] v);
    load_mdr(v);
    dp.s_MDR = 1;
    case (n)
      1: dp.e_R1 = 1;
      2: dp.e_R2 = 1;
      3: dp.e_R3 = 1;
      4: dp.e_R4 = 1;
      default: dp.e_R5 = 1;
    endcase
    #1 chk($sformatf("bus_to_r%0d", n), {32'h0, dp.o_bus}, {32'h0, v});
    tick();
  endtask

  task automatic set_sels(input logic [7:0] m);
    {dp.s_PC, dp.s_Zhigh, dp.s_Zlow, dp.s_MDR, dp.s_R2, dp.s_R3, dp.s_R4, dp.s_R5} = m;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"},  {32'h0, dp.o_PC},  64'h0);
    chk({tag, "_ir"},  {32'h0, dp.o_IR},  64'h0);
    chk({tag, "_mar"}, {32'h0, dp.o_MAR}, 64'h0);
    chk({tag, "_hi"},  {32'h0, dp.o_HI},  64'h0);
    chk({tag, "_lo"},  {32'h0, dp.o_LO},  64'h0);
    chk({tag, "_z"},   dp.o_Z,            64'h0);
    chk({tag, "_bus"}, {32'h0, dp.o_bus}, 64'h0);
  endtask

  initial begin
    logic [5:0]  ops[16];
    logic [31:0] a, b, pv[8];
    logic [63:0] exp;
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
            6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd31, 6'd33};
    idle();
    w_clear = 1'b1;
    dp.s_MDR = 1;
    #12;
    chk_all_zero("reset");
    idle();
    w_clear = 1'b0;
    {m_pc, m_mdr, m_y, m_hi, m_lo, m_r2, m_r3, m_r4, m_r5} = '0;
    m_z = '0;

    load_rn(4, 32'd21); m_r4 = 32'd21;
    load_rn(5, 32'd7);  m_r5 = 32'd7;
    load_rn(1, 32'h18);
    dp.s_R4 = 1;
    #1 chk("r4_on_bus", {32'h0, dp.o_bus}, 64'd21);
    idle();
    dp.s_R5 = 1;
    #1 chk("r5_on_bus", {32'h0, dp.o_bus}, 64'd7);
    idle();

    // PC fetch from reset
    dp.s_PC = 1; dp.e_MAR = 1; dp.w_IncPC = 1; dp.e_Z = 1;
    #1 chk("fetch_bus", {32'h0, dp.o_bus}, 64'h0);
    expect_reg("fetch_mar", S_MAR, 64'h0);
    expect_reg("fetch_z", S_Z, 64'h1);
    tick();
    dp.s_Zlow = 1; dp.e_PC = 1;
    expect_reg("fetch_pc", S_PC, 64'h1);
    tick();
    m_pc = 32'h1;
    dp.s_PC = 1; dp.w_IncPC = 1; dp.e_alu = 1; dp.opcode = 6'd1; dp.e_Z = 1;
    expect_reg("incpc_over_alu", S_Z, 64'h2);
    tick();
    dp.s_Zlow = 1; dp.w_IncPC = 1; dp.e_Z = 1;
    #1 chk("rmw_bus_old", {32'h0, dp.o_bus}, 64'h2);
    expect_reg("rmw_z_new", S_Z, 64'h3);
    tick();
    m_z = 64'h3;

    // Division 21 / 7
    dp.s_R4 = 1; dp.e_Y = 1;
    tick();
    m_y = 32'd21;
    dp.s_R5 = 1; dp.e_alu = 1; dp.opcode = 6'd6; dp.e_Z = 1;
    exp = MD ? 64'h3 : 64'h0;
    expect_reg("div_21_7", S_Z, exp);
    tick();
    m_z = exp;
    z_to_hilo("div_move");

    set_y(32'hFFFF_FFFF);
    alu_op("mul_m1_2", 6'd5, 32'd2, MD ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h0);
    z_to_hilo("mul_move");
    set_y(32'd9);
    alu_op("div_by_0", 6'd6, 32'd0, MD ? 64'h0000_0009_FFFF_FFFF : 64'h0);
    set_y(32'h8000_0000);
    alu_op("div_ovf", 6'd6, 32'hFFFF_FFFF, MD ? 64'h0000_0000_8000_0000 : 64'h0);
    set_y(32'hFFFF_FFF9);
    alu_op("div_neg", 6'd6, 32'd2, MD ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0);

    set_y(32'h8000_0001);
    alu_op("rol",  6'd7,  32'd1, 64'h3);
    alu_op("ror",  6'd8,  32'd1, 64'hC000_0000);
    alu_op("shr",  6'd9,  32'd1, 64'h4000_0000);
    alu_op("shra", 6'd10, 32'd1, 64'hC000_0000);
    alu_op("shl",  6'd11, 32'd1, 64'h2);
    alu_op("neg",  6'd12, 32'd1, 64'hFFFF_FFFF);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      set_y(a);
      for (int k = 0; k < 16; k++) begin
        b = $urandom;
        alu_op($sformatf("rand%0d_op%0d", i, ops[k]), ops[k], b, alu_ref(ops[k], a, b));
      end
      z_to_hilo($sformatf("rand%0d_move", i));
    end

    // Z captures zero when neither w_IncPC nor e_alu is set
    load_mdr(32'h5A5A_0001);
    dp.s_MDR = 1; dp.e_Z = 1; dp.opcode = 6'd0;
    expect_reg("z_no_op", S_Z, 64'h0);
    tick();
    m_z = 64'h0;
    alu_op("z_refill", 6'd3, 32'h0F0F_0000, alu_ref(6'd3, m_y, 32'h0F0F_0000));

    load_mdr(32'h1234_5678);
    dp.s_MDR = 1; dp.e_IR = 1;
    expect_reg("ir_load", S_IR, 64'h1234_5678);
    tick();

    load_rn(2, 32'h2222_0002); m_r2 = 32'h2222_0002;
    load_rn(3, 32'h3333_0003); m_r3 = 32'h3333_0003;
    load_mdr(32'hA5A5_0004);
    pv = '{m_pc, m_z[63:32], m_z[31:0], m_mdr, m_r2, m_r3, m_r4, m_r5};
    for (int i = 0; i <= 8; i++) begin
      set_sels(8'hFF >> i);
      #1 chk($sformatf("bus_prio%0d", i), {32'h0, dp.o_bus}, {32'h0, (i < 8) ? pv[i] : 32'h0});
    end
    idle();

    // Asynchronous clear away from any clock edge, then held across an edge
    dp.s_MDR = 1;
    #2;
    w_clear = 1'b1;
    #1;
    chk_all_zero("async_clr");
    dp.w_Mdatain = 32'd5; dp.w_read = 1; dp.e_MDR = 1; dp.e_PC = 1; dp.s_MDR = 1;
    expect_reg("clr_hold_pc", S_PC, 64'h0);
    tick();
    dp.s_MDR = 1;
    #1 chk("clr_hold_mdr", {32'h0, dp.o_bus}, 64'h0);
    idle();
    #2 w_clear = 1'b0;
    @(posedge w_clock);
    #1;
    idle();
    load_mdr(32'd5);
    dp.s_MDR = 1;
    #1 chk("post_clr_mdr", {32'h0, dp.o_bus}, 64'd5);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
